adsr_envelope_gen: RTL and testbench

Parametrised ADSR volume-envelope generator, successor to the attack/sustain/release one-shot enveloper.
- Adds a decay stage, a runtime sustain level and per-stage runtime rate increments.
- Level updates on a sample-rate tick strobe instead of every mclk.
- Retriggers from the current level, so there is no click.
- Drives the volume input of volume_adjust in each voice source.

---
 rtl/adsr_envelope_gen_pkg.sv | 21 ++
 rtl/adsr_envelope_gen_sat_step.sv | 39 +++
 rtl/adsr_envelope_gen.sv | 144 ++++++++++++++
 tb/tb_adsr_envelope_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_envelope_gen_pkg.sv
// env_pkg: shared types and sizing helpers for the ADSR envelope generator.
//   state_t  : envelope stage encoding, also exported on the stage port
//   STAGE_W  : width of the stage port
//   acc_bits : accumulator width derived from volume and fraction widths
package env_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int STAGE_W = 3;

  function automatic int acc_bits(input int vol_bits, input int frac_bits);
    return vol_bits + frac_bits;
  endfunction

endpackage

// File: rtl/adsr_envelope_gen_sat_step.sv
// env_sat_step: combinational saturating step of the level accumulator.
//   acc_i       : current level
//   inc_i       : step size (zero means jump straight to the bound)
//   bound_i     : ceiling when stepping up, floor when stepping down
//   dir_i       : 1 = add toward ceiling, 0 = subtract toward floor
//   next_acc_o  : stepped level, clamped to bound_i
//   hit_bound_o : the step reached (or would cross) the bound
module env_sat_step #(
  parameter int ACC_BITS = 24
) (
  input  logic [ACC_BITS-1:0] acc_i,
  input  logic [ACC_BITS-1:0] inc_i,
  input  logic [ACC_BITS-1:0] bound_i,
  input  logic                dir_i,
  output logic [ACC_BITS-1:0] next_acc_o,
  output logic                hit_bound_o
);

  // One extra bit on both sums so neither the add nor the floor+inc compare wraps.
  logic [ACC_BITS:0] sum_w;
  logic [ACC_BITS:0] floor_w;

  assign sum_w   = {1'b0, acc_i} + {1'b0, inc_i};
  assign floor_w = {1'b0, bound_i} + {1'b0, inc_i};

  always_comb begin
    if (dir_i) begin
      hit_bound_o = (inc_i == '0) || (sum_w >= {1'b0, bound_i});
    end else begin
      // Floor reached if one more step would land on/under it, or if the
      // floor has moved above the level (live sustain raised mid-decay).
      hit_bound_o = (inc_i == '0) || ({1'b0, acc_i} <= floor_w) || (bound_i > acc_i);
    end
    if (hit_bound_o)  next_acc_o = bound_i;
    else if (dir_i)   next_acc_o = sum_w[ACC_BITS-1:0];
    else              next_acc_o = acc_i - inc_i;
  end

endmodule

// File: rtl/adsr_envelope_gen.sv
// adsr_envelope_gen: ADSR volume envelope, level stepped on the sample tick.
//   mclk, rst_n      : master clock, async active-low reset
//   tick             : one-mclk sample-rate strobe; level steps only here
//   gate             : rising edge starts ATTACK, low requests RELEASE
//   attack_inc/decay_inc/release_inc : per-tick level step per stage
//   sustain_level    : sustain target, sampled live
//   oneshot          : (only with ADSR_ONESHOT_EN) ignore gate-low, DECAY
//                      exits straight into RELEASE
//   env_out          : registered top VOLUME_BITS of the accumulator
//   stage            : current state_t
//   busy             : registered, stage != IDLE
// Optional feature macro: ADSR_ONESHOT_EN.
module adsr_envelope_gen
  import env_pkg::*;
#(
  parameter int VOLUME_BITS = 8,
  parameter int FRAC_BITS   = 16,
  parameter int RATE_BITS   = 16
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   gate,
  input  logic [RATE_BITS-1:0]   attack_inc,
  input  logic [RATE_BITS-1:0]   decay_inc,
  input  logic [VOLUME_BITS-1:0] sustain_level,
  input  logic [RATE_BITS-1:0]   release_inc,
`ifdef ADSR_ONESHOT_EN
  input  logic                   oneshot,
`endif
  output logic [VOLUME_BITS-1:0] env_out,
  output logic [STAGE_W-1:0]     stage,
  output logic                   busy
);

  localparam int ACC_BITS = acc_bits(VOLUME_BITS, FRAC_BITS);
  localparam logic [ACC_BITS-1:0] MAX = '1;

  generate
    if (RATE_BITS > ACC_BITS) begin : g_bad_rate
      $error("adsr_envelope_gen: RATE_BITS must not exceed VOLUME_BITS+FRAC_BITS");
    end
  endgenerate

  state_t                 state_q;
  logic [ACC_BITS-1:0]    acc_q;
  logic                   gate_q;
  logic [VOLUME_BITS-1:0] env_q;
  logic                   busy_q;

  logic                   os_en;
  logic                   rise;
  logic [ACC_BITS-1:0]    sus_acc;
  logic [ACC_BITS-1:0]    step_inc;
  logic [ACC_BITS-1:0]    step_bound;
  logic                   step_up;
  logic [ACC_BITS-1:0]    step_acc_d;
  logic                   step_hit;

`ifdef ADSR_ONESHOT_EN
  assign os_en = oneshot;
`else
  assign os_en = 1'b0;
`endif

  assign rise    = gate & ~gate_q;
  assign sus_acc = ACC_BITS'(sustain_level) << FRAC_BITS;

  // Only one stage steps per tick, so a single stepper is shared; the
  // increment is picked from the port of the stage that uses it.
  always_comb begin
    step_inc   = ACC_BITS'(release_inc);
    step_bound = '0;
    step_up    = 1'b0;
    case (state_q)
      ATTACK: begin
        step_inc   = ACC_BITS'(attack_inc);
        step_bound = MAX;
        step_up    = 1'b1;
      end
      DECAY: begin
        step_inc   = ACC_BITS'(decay_inc);
        step_bound = sus_acc;
      end
      default: ;
    endcase
  end

  env_sat_step #(.ACC_BITS(ACC_BITS)) u_step (
    .acc_i       (acc_q),
    .inc_i       (step_inc),
    .bound_i     (step_bound),
    .dir_i       (step_up),
    .next_acc_o  (step_acc_d),
    .hit_bound_o (step_hit)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      gate_q  <= 1'b0;
      env_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      gate_q <= gate;
      env_q  <= acc_q[ACC_BITS-1 -: VOLUME_BITS];
      busy_q <= (state_q != IDLE);
      // Stage changes from gate events leave the level untouched (click-free
      // retrigger/release) and suppress that cycle's tick step.
      if (rise) begin
        state_q <= ATTACK;
      end else if (!gate && !os_en &&
                   (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_q <= RELEASE;
      end else if (tick) begin
        case (state_q)
          ATTACK: begin
            acc_q <= step_acc_d;
            if (step_hit) state_q <= DECAY;
          end
          DECAY: begin
            acc_q <= step_acc_d;
            if (step_hit) state_q <= os_en ? RELEASE : SUSTAIN;
          end
          SUSTAIN: acc_q <= sus_acc;
          RELEASE: begin
            acc_q <= step_acc_d;
            if (step_hit) state_q <= IDLE;
          end
          default: begin
            acc_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign env_out = env_q;
  assign stage   = state_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Bench for adsr_envelope_gen with VOLUME_BITS=8, FRAC_BITS=8, RATE_BITS=16,
// tick every 4 mclk. A cycle-level integer reference model runs alongside.
module tb_adsr_envelope_gen;

  localparam int ST_IDLE = 0, ST_ATT = 1, ST_DEC = 2, ST_SUS = 3, ST_REL = 4;
  localparam int MAXV = 65535;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] attack_inc = '0, decay_inc = '0, release_inc = '0;
  logic [7:0]  sustain_level = '0;
  logic [7:0]  env_out;
  logic [2:0]  stage;
  logic        busy;
`ifdef ADSR_ONESHOT_EN
  logic        oneshot = 1'b0;
`endif

  int nerr = 0, nchk = 0, tcnt = 0;

  always #5 mclk = ~mclk;

  adsr_envelope_gen #(.VOLUME_BITS(8), .FRAC_BITS(8), .RATE_BITS(16)) dut (
    .mclk(mclk), .rst_n(rst_n), .tick(tick), .gate(gate),
    .attack_inc(attack_inc), .decay_inc(decay_inc),
    .sustain_level(sustain_level), .release_inc(release_inc),
`ifdef ADSR_ONESHOT_EN
    .oneshot(oneshot),
`endif
    .env_out(env_out), .stage(stage), .busy(busy)
  );

  // Reference model: integer level, stage numbers from the spec ordering.
  int         m_acc = 0, m_st = ST_IDLE;
  logic       m_gq = 1'b0, m_busy = 1'b0;
  logic [7:0] m_env = '0;
  logic       m_os;
`ifdef ADSR_ONESHOT_EN
  assign m_os = oneshot;
`else
  assign m_os = 1'b0;
`endif

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_st = ST_IDLE; m_gq = 1'b0; m_env = '0; m_busy = 1'b0;
    end else begin
      int s, nacc, nst;
      s = int'(sustain_level) * 256;
      nacc = m_acc; nst = m_st;
      if (gate && !m_gq) nst = ST_ATT;
      else if (!gate && !m_os && m_st >= ST_ATT && m_st <= ST_SUS) nst = ST_REL;
      else if (tick) begin
        case (m_st)
          ST_ATT: if (attack_inc == 0 || m_acc + int'(attack_inc) >= MAXV) begin
                    nacc = MAXV; nst = ST_DEC;
                  end else nacc = m_acc + int'(attack_inc);
          ST_DEC: if (decay_inc == 0 || m_acc <= s + int'(decay_inc)) begin
                    nacc = s; nst = m_os ? ST_REL : ST_SUS;
                  end else nacc = m_acc - int'(decay_inc);
          ST_SUS: nacc = s;
          ST_REL: if (release_inc == 0 || m_acc <= int'(release_inc)) begin
                    nacc = 0; nst = ST_IDLE;
                  end else nacc = m_acc - int'(release_inc);
          default: nacc = 0;
        endcase
      end
      m_env  = 8'(m_acc >> 8);
      m_busy = (m_st != ST_IDLE);
      m_gq   = gate;
      m_acc  = nacc;
      m_st   = nst;
    end
  end

  // Advance one mclk; return 1 ns after the edge. tick is high every 4th cycle.
  task automatic adv();
    @(posedge mclk); #1;
    tcnt++;
    tick = (tcnt % 4 == 0);
  endtask

  function automatic logic [15:0] rnd_inc();
    if ($urandom_range(0, 7) == 0) return 16'h0;
    if ($urandom_range(0, 7) == 0) return 16'(($urandom_range(0, 65535)));
    return 16'($urandom_range(1, 16'h2000));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; gate = 1'b0;
    attack_inc = 16'h0800; decay_inc = 16'h0800; release_inc = 16'h0400; sustain_level = 8'h80;
    repeat (3) adv();
    nchk++;
    if ({env_out, stage, busy} !== 12'h0) begin
      nerr++; $display("FAIL reset_state: got env=%h stage=%0d busy=%b, want 0/0/0", env_out, stage, busy);
    end
    rst_n = 1'b1; gate = 1'b1;
    for (int i = 0; i < 400 && m_acc < 32'h8000; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL reset_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
    end
    #1 rst_n = 1'b0; #1;
    nchk++; if (env_out !== 8'h0) begin nerr++; $display("FAIL reset_async_env: got %h want 00", env_out); end
    nchk++; if (stage !== 3'd0) begin nerr++; $display("FAIL reset_async_stage: got %0d want 0", stage); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_async_busy: got %b want 0", busy); end
    gate = 1'b0;
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      adv(); nchk++;
      if (stage !== 3'd0 || env_out !== 8'h0 || busy !== 1'b0) begin
        nerr++; $display("FAIL reset_stay_idle: got %h/%0d/%b want 00/0/0", env_out, stage, busy);
      end
    end
  endtask

  task automatic test_attack();
    logic [7:0] seen[$];
    logic [7:0] prev;
    attack_inc = 16'h1000; decay_inc = 16'h0800; sustain_level = 8'h80; gate = 1'b1;
    prev = env_out;
    for (int i = 0; i < 300; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL attack_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
      if (env_out !== prev) begin seen.push_back(env_out); prev = env_out; end
      if (env_out == 8'hFF) break;
    end
    nchk++;
    if (seen.size() != 16) begin nerr++; $display("FAIL attack_step_count: got %0d want 16", seen.size()); end
    for (int k = 0; k < 16 && k < seen.size(); k++) begin
      logic [7:0] exp_v;
      exp_v = (k < 15) ? 8'((k + 1) * 16) : 8'hFF;
      nchk++;
      if (seen[k] !== exp_v) begin nerr++; $display("FAIL attack_step%0d: got %h want %h", k, seen[k], exp_v); end
    end
    nchk++;
    if (stage !== 3'd2) begin nerr++; $display("FAIL attack_to_decay: got stage %0d want 2", stage); end
  endtask

  task automatic test_decay_sustain();
    for (int i = 0; i < 300 && stage != 3'd3; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL decay_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
    end
    nchk++; if (stage !== 3'd3) begin nerr++; $display("FAIL decay_to_sustain: got stage %0d want 3", stage); end
    adv();
    nchk++; if (env_out !== 8'h80) begin nerr++; $display("FAIL sustain_land: got %h want 80", env_out); end
    sustain_level = 8'h40;
    repeat (8) adv();
    nchk++; if (env_out !== 8'h40) begin nerr++; $display("FAIL sustain_live: got %h want 40", env_out); end
  endtask

  task automatic test_release();
    int nt;
    sustain_level = 8'h80;
    repeat (8) adv();
    nchk++; if (env_out !== 8'h80) begin nerr++; $display("FAIL sustain_raise: got %h want 80", env_out); end
    release_inc = 16'h0400; gate = 1'b0;
    adv();
    nchk++; if (stage !== 3'd4) begin nerr++; $display("FAIL release_enter: got stage %0d want 4", stage); end
    nchk++; if (env_out !== 8'h80) begin nerr++; $display("FAIL release_start: got %h want 80", env_out); end
    nt = 0;
    for (int i = 0; i < 400; i++) begin
      if (tick && stage == 3'd4) nt++;
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL release_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
      if (stage == 3'd0) break;
    end
    nchk++; if (nt != 32) begin nerr++; $display("FAIL release_ticks: got %0d want 32", nt); end
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL busy_lag: got %b want 1", busy); end
    adv();
    nchk++; if (busy !== 1'b0 || env_out !== 8'h0) begin
      nerr++; $display("FAIL release_idle: got busy=%b env=%h want 0/00", busy, env_out);
    end
    // gate drop mid-attack releases from the current level
    attack_inc = 16'h1000; gate = 1'b1;
    for (int i = 0; i < 300 && env_out != 8'h60; i++) adv();
    gate = 1'b0;
    adv();
    nchk++; if (stage !== 3'd4 || env_out !== 8'h60) begin
      nerr++; $display("FAIL release_from_attack: got stage=%0d env=%h want 4/60", stage, env_out);
    end
    for (int i = 0; i < 400 && stage != 3'd0; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL release2_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
    end
  endtask

  task automatic test_retrigger();
    attack_inc = 16'h1000; decay_inc = 16'h0800; sustain_level = 8'h80; gate = 1'b1;
    for (int i = 0; i < 400 && stage != 3'd3; i++) adv();
    repeat (8) adv();
    release_inc = 16'h0400; gate = 1'b0;
    for (int i = 0; i < 400 && env_out != 8'h30; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL retrig_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
    end
    for (int i = 0; i < 8 && !tick; i++) adv();
    // rise lands on the same edge as a tick
    gate = 1'b1; attack_inc = 16'h0100;
    adv();
    nchk++; if (stage !== 3'd1) begin nerr++; $display("FAIL retrig_stage: got %0d want 1", stage); end
    adv();
    nchk++; if (env_out !== 8'h30) begin nerr++; $display("FAIL retrig_tick_hold: got %h want 30", env_out); end
    for (int i = 0; i < 20 && env_out == 8'h30; i++) adv();
    nchk++; if (env_out !== 8'h31) begin nerr++; $display("FAIL retrig_continue: got %h want 31", env_out); end
  endtask

  task automatic test_boundaries();
    gate = 1'b0; release_inc = 16'h2000;
    for (int i = 0; i < 200 && stage != 3'd0; i++) adv();
    attack_inc = 16'h0; decay_inc = 16'h0800; gate = 1'b1;
    for (int i = 0; i < 20 && !(tick && stage == 3'd1); i++) adv();
    adv(); adv();
    nchk++; if (env_out !== 8'hFF || stage !== 3'd2) begin
      nerr++; $display("FAIL attack_zero_inc: got env=%h stage=%0d want FF/2", env_out, stage);
    end
    release_inc = 16'h0; gate = 1'b0;
    for (int i = 0; i < 20 && !(tick && stage == 3'd4); i++) adv();
    adv(); adv();
    nchk++; if (env_out !== 8'h00 || stage !== 3'd0) begin
      nerr++; $display("FAIL release_zero_inc: got env=%h stage=%0d want 00/0", env_out, stage);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) attack_inc = rnd_inc();
      if ($urandom_range(0, 49) == 0) decay_inc = rnd_inc();
      if ($urandom_range(0, 49) == 0) release_inc = rnd_inc();
      if ($urandom_range(0, 99) == 0) sustain_level = 8'($urandom_range(0, 255));
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL random_model: cyc=%0d got %h/%0d/%b want %h/%0d/%b", i, env_out, stage, busy, m_env, m_st, m_busy);
      end
    end
  endtask

`ifdef ADSR_ONESHOT_EN
  task automatic test_oneshot();
    bit saw_sus, saw_rel;
    saw_sus = 0; saw_rel = 0;
    gate = 1'b0; rst_n = 1'b0; adv(); rst_n = 1'b1; adv();
    oneshot = 1'b1;
    attack_inc = 16'h1000; decay_inc = 16'h0800; sustain_level = 8'h80; release_inc = 16'h0400;
    gate = 1'b1; adv(); gate = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      adv(); nchk++;
      if (env_out !== m_env || stage !== m_st[2:0] || busy !== m_busy) begin
        nerr++; $display("FAIL oneshot_model: got %h/%0d/%b want %h/%0d/%b", env_out, stage, busy, m_env, m_st, m_busy);
      end
      if (stage == 3'd3) saw_sus = 1;
      if (stage == 3'd4) saw_rel = 1;
      if (stage == 3'd0) break;
    end
    nchk++; if (saw_sus || !saw_rel || stage !== 3'd0) begin
      nerr++; $display("FAIL oneshot_path: got sus=%0d rel=%0d stage=%0d want 0/1/0", saw_sus, saw_rel, stage);
    end
    oneshot = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_boundaries();
    test_random();
`ifdef ADSR_ONESHOT_EN
    test_oneshot();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
